byte_fetch_unit: RTL and testbench

Reads the byte-wide program memory that the bench loads from `bytecode.bin`. Assembles consecutive bytes little-endian into 32-bit instruction words and hands them to the decode stage over a valid/ready handshake. Stops when it meets the 0xFF end-of-program marker at an instruction boundary. Sits between the program memory and the microprocessor's decoder.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_word_assembler.sv | 37 +++
 rtl/byte_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_byte_fetch_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the byte fetch unit and its word assembler.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        VALID,
        HALT
    } fetch_state_t;

    localparam logic [7:0] HALT_BYTE   = 8'hFF;
    localparam int         INSTR_BYTES = 4;
    localparam int         CNT_W       = 3;

    function automatic logic is_halt_byte(input logic [7:0] b);
        return b == HALT_BYTE;
    endfunction

endpackage

// File: rtl/fetch_word_assembler.sv
// Lane-indexed byte capture register; word_o already reflects a byte being captured
// this cycle so the fetch FSM can register the complete word on the final capture.
module fetch_word_assembler
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        capture_i,
    input  logic [1:0]  lane_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o
);

    logic [INSTR_BYTES-1:0][7:0] lanes_q;
    logic [INSTR_BYTES-1:0][7:0] lanes_d;

    always_comb begin
        lanes_d = lanes_q;
        if (clear_i) begin
            lanes_d = '0;
        end else if (capture_i) begin
            lanes_d[lane_i] = byte_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_q <= '0;
        end else begin
            lanes_q <= lanes_d;
        end
    end

    assign word_o = lanes_d;

endmodule

// File: rtl/byte_fetch_unit.sv
// Fetches bytes from program memory and assembles little-endian 32-bit words for decode.
// Define FETCH_HALT_DETECT_EN to stop on a 0xFF marker at a word boundary.
module byte_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INSTR_BYTES);

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [CNT_W-1:0]  byte_cnt_q;
    logic              mem_rd_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              instr_valid_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              halted_q;

    logic [ADDR_W-1:0] fetch_base_d;
    logic [ADDR_W-1:0] next_addr_d;
    logic [ADDR_W-1:0] pc_plus4_d;
    logic              start_d;
    logic              handshake_d;
    logic              asm_clear_d;
    logic              asm_capture_d;
    logic [1:0]        asm_lane_d;
    logic [31:0]       asm_word_d;
    logic              halt_hit_d;

    // Read strobe/address are registered one cycle ahead, so they are derived
    // from the count the FSM is about to move into.
    always_comb begin
        fetch_base_d  = redirect ? redirect_pc : pc_q;
        next_addr_d   = pc_q + ADDR_W'(byte_cnt_q + 3'd1);
        pc_plus4_d    = pc_q + ADDR_W'(INSTR_BYTES);
        start_d       = (state_q == IDLE) && enable;
        handshake_d   = (state_q == VALID) && instr_ready;
        asm_clear_d   = start_d || handshake_d || (redirect && (state_q != IDLE));
        asm_capture_d = (state_q == FETCH) && !redirect && (byte_cnt_q != '0);
        asm_lane_d    = byte_cnt_q[1:0] - 2'd1;
`ifdef FETCH_HALT_DETECT_EN
        halt_hit_d    = (state_q == FETCH) && !redirect && (byte_cnt_q == 3'd1)
                        && is_halt_byte(mem_rdata);
`else
        halt_hit_d    = 1'b0;
`endif
    end

    fetch_word_assembler u_assembler (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (asm_clear_d),
        .capture_i (asm_capture_d),
        .lane_i    (asm_lane_d),
        .byte_i    (mem_rdata),
        .word_o    (asm_word_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            byte_cnt_q    <= '0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            halted_q      <= 1'b0;
        end else if (redirect && (state_q != IDLE)) begin
            // Restarting at byte 0 also drops any byte returning from the old stream.
            state_q       <= FETCH;
            pc_q          <= redirect_pc;
            byte_cnt_q    <= '0;
            mem_rd_q      <= 1'b1;
            mem_addr_q    <= redirect_pc;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect) begin
                        pc_q <= redirect_pc;
                    end
                    if (enable) begin
                        state_q    <= FETCH;
                        byte_cnt_q <= '0;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= fetch_base_d;
                    end
                end
                FETCH: begin
                    if (byte_cnt_q == LAST_CNT) begin
                        state_q       <= VALID;
                        byte_cnt_q    <= '0;
                        mem_rd_q      <= 1'b0;
                        instr_valid_q <= 1'b1;
                        instr_q       <= asm_word_d;
                        instr_pc_q    <= pc_q;
                    end else if (halt_hit_d) begin
                        state_q    <= HALT;
                        byte_cnt_q <= '0;
                        mem_rd_q   <= 1'b0;
                        halted_q   <= 1'b1;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                        mem_rd_q   <= (byte_cnt_q != (LAST_CNT - 3'd1));
                        mem_addr_q <= next_addr_d;
                    end
                end
                VALID: begin
                    if (instr_ready) begin
                        state_q       <= FETCH;
                        pc_q          <= pc_plus4_d;
                        byte_cnt_q    <= '0;
                        mem_rd_q      <= 1'b1;
                        mem_addr_q    <= pc_plus4_d;
                        instr_valid_q <= 1'b0;
                    end
                end
                HALT: begin
                    mem_rd_q <= 1'b0;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_byte_fetch_unit.sv
// Directed testbench for byte_fetch_unit with a one-cycle-latency byte memory model.
module tb_byte_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        mem_rd;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        instr_valid;
    logic [31:0] instr;
    logic [9:0]  instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [9:0]  redirect_pc = 10'h000;
    logic        halted;

    logic [7:0]  mem [0:1023];
    logic [9:0]  expAddr [4];
    logic [31:0] expWord [3];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    byte_fetch_unit #(
        .ADDR_W   (10),
        .RESET_PC (10'h000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    task clearMem();
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    endtask

    task applyReset();
        rst_n = 1'b0;
        enable = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = 10'h000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task test_reset();
        @(negedge clk);
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_rd got=%b exp=0", mem_rd); end
        checks++; if (mem_addr !== 10'h000) begin errors++; $display("[TB] FAIL reset_mem_addr got=%h exp=000", mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_instr_valid got=%b exp=0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr got=%h exp=00000000", instr); end
        checks++; if (instr_pc !== 10'h000) begin errors++; $display("[TB] FAIL reset_instr_pc got=%h exp=000", instr_pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted got=%b exp=0", halted); end
        rst_n = 1'b1;
    endtask

    task test_basic();
        clearMem();
        mem[0] = 8'h13;
        applyReset();
        repeat (3) @(negedge clk);
        enable = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) enable = 1'b0;
            if (k <= 4) begin
                checks++;
                if (mem_rd !== 1'b1 || mem_addr !== 10'(k - 1)) begin
                    errors++;
                    $display("[TB] FAIL basic_read%0d got rd=%b addr=%h exp rd=1 addr=%h", k, mem_rd, mem_addr, 10'(k - 1));
                end
            end else if (k == 5) begin
                checks++;
                if (mem_rd !== 1'b0 || instr_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL basic_gap got rd=%b valid=%b exp rd=0 valid=0", mem_rd, instr_valid);
                end
            end else begin
                checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid_latency got=%b exp=1", instr_valid); end
                checks++; if (instr !== 32'h00000013) begin errors++; $display("[TB] FAIL basic_instr got=%h exp=00000013", instr); end
                checks++; if (instr_pc !== 10'h000) begin errors++; $display("[TB] FAIL basic_instr_pc got=%h exp=000", instr_pc); end
            end
        end
    endtask

    task test_stall();
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr !== 32'h00000013 || instr_pc !== 10'h000 || mem_rd !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d got valid=%b instr=%h pc=%h rd=%b exp 1/00000013/000/0",
                         i, instr_valid, instr, instr_pc, mem_rd);
            end
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release_valid got=%b exp=0", instr_valid); end
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 10'h004) begin
            errors++;
            $display("[TB] FAIL stall_next_fetch got rd=%b addr=%h exp rd=1 addr=004", mem_rd, mem_addr);
        end
    endtask

`ifdef FETCH_HALT_DETECT_EN
    task test_halt();
        clearMem();
        mem[0] = 8'h93; mem[1] = 8'h00; mem[2] = 8'h50; mem[3] = 8'h00; mem[4] = 8'hFF;
        applyReset();
        instr_ready = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            enable = 1'b0;
            if (instr_valid === 1'b1) break;
        end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL halt_first_word_timeout got valid=%b exp=1", instr_valid); end
        checks++; if (instr !== 32'h00500093) begin errors++; $display("[TB] FAIL halt_first_instr got=%h exp=00500093", instr); end
        checks++; if (instr_pc !== 10'h000) begin errors++; $display("[TB] FAIL halt_first_pc got=%h exp=000", instr_pc); end
        @(negedge clk);
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 10'h004) begin
            errors++;
            $display("[TB] FAIL halt_marker_read got rd=%b addr=%h exp rd=1 addr=004", mem_rd, mem_addr);
        end
        @(negedge clk);
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_early got=%b exp=0", halted); end
        @(negedge clk);
        checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_latency got=%b exp=1", halted); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (halted !== 1'b1 || mem_rd !== 1'b0 || instr_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL halt_hold%0d got halted=%b rd=%b valid=%b exp 1/0/0", i, halted, mem_rd, instr_valid);
            end
        end
        redirect = 1'b1;
        redirect_pc = 10'h000;
        @(negedge clk);
        redirect = 1'b0;
        instr_ready = 1'b0;
        checks++;
        if (halted !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 10'h000) begin
            errors++;
            $display("[TB] FAIL halt_redirect_exit got halted=%b rd=%b addr=%h exp 0/1/000", halted, mem_rd, mem_addr);
        end
    endtask
`else
    task test_ff_word();
        logic sawHalt;
        clearMem();
        for (int i = 0; i < 4; i++) mem[i] = 8'hFF;
        applyReset();
        sawHalt = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            enable = 1'b0;
            if (halted !== 1'b0) sawHalt = 1'b1;
            if (instr_valid === 1'b1) break;
        end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL ff_word_timeout got valid=%b exp=1", instr_valid); end
        checks++; if (instr !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL ff_word_instr got=%h exp=ffffffff", instr); end
        checks++; if (sawHalt !== 1'b0) begin errors++; $display("[TB] FAIL ff_word_halted got=%b exp=0", sawHalt); end
    endtask
`endif

    task test_redirect();
        clearMem();
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + i);
        mem[10'h3FE] = 8'hAA;
        mem[10'h3FF] = 8'hBB;
        expAddr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        applyReset();
        enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            enable = 1'b0;
        end
        redirect = 1'b1;
        redirect_pc = 10'h3FE;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            redirect = 1'b0;
            if (j == 1) begin
                checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL redirect_no_partial got valid=%b exp=0", instr_valid); end
            end
            if (j <= 4) begin
                checks++;
                if (mem_rd !== 1'b1 || mem_addr !== expAddr[j-1]) begin
                    errors++;
                    $display("[TB] FAIL redirect_read%0d got rd=%b addr=%h exp rd=1 addr=%h", j, mem_rd, mem_addr, expAddr[j-1]);
                end
            end else if (j == 5) begin
                checks++; if (mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL redirect_gap got rd=%b exp=0", mem_rd); end
            end else begin
                checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL redirect_valid got=%b exp=1", instr_valid); end
                checks++; if (instr !== 32'h1110BBAA) begin errors++; $display("[TB] FAIL redirect_instr got=%h exp=1110bbaa", instr); end
                checks++; if (instr_pc !== 10'h3FE) begin errors++; $display("[TB] FAIL redirect_instr_pc got=%h exp=3fe", instr_pc); end
            end
        end
    endtask

    task test_reset_midfetch();
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL midreset_mem_rd got=%b exp=0", mem_rd); end
        checks++; if (mem_addr !== 10'h000) begin errors++; $display("[TB] FAIL midreset_mem_addr got=%h exp=000", mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid got=%b exp=0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("[TB] FAIL midreset_instr got=%h exp=00000000", instr); end
        checks++; if (instr_pc !== 10'h000) begin errors++; $display("[TB] FAIL midreset_instr_pc got=%h exp=000", instr_pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL midreset_halted got=%b exp=0", halted); end
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (mem_rd !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_idle%0d got rd=%b valid=%b halted=%b exp 0/0/0", i, mem_rd, instr_valid, halted);
            end
        end
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 10'h000) begin
            errors++;
            $display("[TB] FAIL midreset_restart got rd=%b addr=%h exp rd=1 addr=000", mem_rd, mem_addr);
        end
    endtask

    task test_back_to_back();
        int nWords;
        clearMem();
        for (int i = 0; i < 12; i++) mem[i] = 8'(i + 1);
        expWord = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
        applyReset();
        instr_ready = 1'b1;
        nWords = 0;
        enable = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            enable = 1'b0;
            if (instr_valid === 1'b1 && nWords < 3) begin
                checks++;
                if (k != 6 * (nWords + 1)) begin
                    errors++;
                    $display("[TB] FAIL b2b_cycle%0d got=%0d exp=%0d", nWords, k, 6 * (nWords + 1));
                end
                checks++;
                if (instr !== expWord[nWords] || instr_pc !== 10'(4 * nWords)) begin
                    errors++;
                    $display("[TB] FAIL b2b_word%0d got instr=%h pc=%h exp instr=%h pc=%h",
                             nWords, instr, instr_pc, expWord[nWords], 10'(4 * nWords));
                end
                nWords++;
            end
        end
        instr_ready = 1'b0;
        checks++; if (nWords != 3) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=3", nWords); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
`ifdef FETCH_HALT_DETECT_EN
        test_halt();
`else
        test_ff_word();
`endif
        test_redirect();
        test_reset_midfetch();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
